s_to_p: RTL and testbench
=========================

Name: s_to_p

Overview:
- Serial-to-parallel deserializer; receiving end of the team's LSB-first serial link driven by the existing parallel-to-serial block.
- Shares that block's active-low EN framing. Captures WIDTH bits after a fixed lead-in, presents the word with a one-cycle VALID pulse, and supplies the word's ones-count for BNN popcount accumulation downstream.

Parameters:
- WIDTH, 16, bits per serial frame (parallel word width, >=2)
- LEAD, 2, rising edges with EN=0 whose samples are discarded before bit 0 (>=0). 2 matches a same-cycle-enabled serializer: registered output plus its leading zero slot.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous reset, active-low
- EN  input  1  frame enable, active-low. EN=1 aborts and clears synchronously.
- S_TO_P_IN  input  1  serial data, LSB first
- S_TO_P_OUT  output  WIDTH  last completed word
- VALID  output  1  one-cycle pulse: S_TO_P_OUT/ONES updated this cycle
- BUSY  output  1  frame in progress (SKIP or SHIFT)
- ONES  output  $clog2(WIDTH+1)  number of 1 bits in S_TO_P_OUT

Behaviour:
- Reset (RST_N=0, async): state=IDLE, CNT=0, shift reg=0, S_TO_P_OUT=0, ONES=0, VALID=0, BUSY=0.
- EN=1 at a rising edge, any state:
  - next state IDLE; CNT, shift reg and running ones-count cleared; VALID=0.
  - S_TO_P_OUT and ONES hold their last completed values.
  - Aborting mid-frame never produces VALID or a partial word.
- Sample index n: 0 at the first edge with EN=0, incremented each edge EN stays 0. CNT width $clog2(LEAD+WIDTH+1).
- States and transitions:
  - IDLE: at an edge with EN=0, go to SKIP (LEAD>1), SHIFT (LEAD=1), or sample bit 0 at this edge into SHIFT (LEAD=0).
  - SKIP: discard samples n<LEAD. Go to SHIFT when n=LEAD-1 is consumed.
  - SHIFT: sample at n=LEAD+k is written to bit k, k=0..WIDTH-1, and the ones-count is incremented by the sampled bit. At k=WIDTH-1, the same edge loads S_TO_P_OUT from the shift reg including the current bit, loads ONES from the final count, sets VALID=1, and moves to DONE.
  - DONE: VALID returns to 0 after one cycle. Holds while EN=0; S_TO_P_IN is ignored. Leaves only via EN=1 to IDLE, giving one word per EN-low window (mirrors the serializer holding its last bit).
- Latency: VALID is high in the cycle after edge n=LEAD+WIDTH-1. For LEAD=2, WIDTH=16, that edge is the 18th EN-low edge.
- BUSY=1 exactly in SKIP and SHIFT (registered with state).
- ONES never exceeds WIDTH. The count register is wide enough for WIDTH with no wrap.
- EN rising at the same edge as the last bit: EN wins; no VALID, outputs unchanged.
- Re-arming: EN=1 for a single cycle is sufficient to start a new frame on the next EN=0 edge.

Test Plan:
- Reset mid-SHIFT: assert RST_N=0 after 5 bits -> all outputs 0 immediately, no VALID after release.
- Loopback with serializer (WIDTH=16, LEAD=2), IN=16'hA5C3, both EN fall the same cycle -> VALID on the 18th edge, S_TO_P_OUT=16'hA5C3, ONES=8, BUSY low from the same edge.
- Direct stream 16'hFFFF, then 16'h0000 after an EN=1 cycle -> ONES=16 then 0; S_TO_P_OUT holds 16'hFFFF until the second VALID.
- Abort: EN=1 after 10 data bits of 16'h1234 -> no VALID, S_TO_P_OUT keeps its prior value. The next full frame 16'h8001 gives ONES=2.
- Hold: EN kept 0 for 40 cycles after VALID while S_TO_P_IN toggles -> exactly one VALID, output stable.
- LEAD=0, WIDTH=4, bits 1,0,1,1 from the first EN-low edge -> S_TO_P_OUT=4'hD, ONES=3, VALID in the cycle after the 4th edge.

Source files
------------

// File: rtl/s_to_p_if.sv
// Serial link bundle between the LSB-first serializer side and the s_to_p deserializer.
// The driver of the link uses master; the deserializer uses slave.
interface s_to_p_if #(
  parameter int WIDTH = 16
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic              EN;
  logic              S_TO_P_IN;
  logic [WIDTH-1:0]  S_TO_P_OUT;
  logic              VALID;
  logic              BUSY;
  logic [ONES_W-1:0] ONES;

  modport master (
    output EN,
    output S_TO_P_IN,
    input  S_TO_P_OUT,
    input  VALID,
    input  BUSY,
    input  ONES
  );

  modport slave (
    input  EN,
    input  S_TO_P_IN,
    output S_TO_P_OUT,
    output VALID,
    output BUSY,
    output ONES
  );
endinterface

// File: rtl/s_to_p.sv
// LSB-first serial-to-parallel deserializer with active-low EN framing, a fixed
// lead-in of discarded samples, one word per EN-low window and a running popcount.
module s_to_p #(
  parameter int WIDTH = 16,
  parameter int LEAD  = 2
) (
  input  logic      CLK,
  input  logic      RST_N,
  s_to_p_if.slave   bus
);

  localparam int CNT_W  = $clog2(LEAD + WIDTH + 1);
  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEAD + WIDTH - 1);
  localparam logic [CNT_W-1:0] SKIP_END = CNT_W'((LEAD > 0) ? LEAD - 1 : 0);
  localparam logic [CNT_W-1:0] LEAD_CNT = CNT_W'(LEAD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [ONES_W-1:0]   run_q, run_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [CNT_W-1:0]    bit_k;
  logic [WIDTH-1:0]    word_w;
  logic [ONES_W-1:0]   run_inc;

  // Writes one sampled bit into position k of the word being assembled.
  function automatic logic [WIDTH-1:0] place_bit(
    input logic [WIDTH-1:0] w,
    input logic             b,
    input logic [CNT_W-1:0] k
  );
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < WIDTH; i++) begin
      if (k == CNT_W'(i)) r[i] = b;
    end
    return r;
  endfunction

  // cnt_q holds the index n of the sample arriving at the next edge.
  assign bit_k   = cnt_q - LEAD_CNT;
  assign word_w  = place_bit(shift_q, bus.S_TO_P_IN, bit_k);
  assign run_inc = run_q + ONES_W'(bus.S_TO_P_IN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    run_d   = run_q;
    out_d   = out_q;
    ones_d  = ones_q;
    valid_d = 1'b0;

    if (bus.EN) begin
      // Abort or idle: completed outputs are kept, frame progress is dropped.
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = CNT_W'(1);
          if (LEAD == 0) begin
            shift_d = place_bit('0, bus.S_TO_P_IN, '0);
            run_d   = ONES_W'(bus.S_TO_P_IN);
            state_d = SHIFT;
          end else if (LEAD == 1) begin
            state_d = SHIFT;
          end else begin
            state_d = SKIP;
          end
        end
        SKIP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == SKIP_END) state_d = SHIFT;
        end
        SHIFT: begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = word_w;
          run_d   = run_inc;
          if (cnt_q == LAST_CNT) begin
            out_d   = word_w;
            ones_d  = run_inc;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SKIP) || (state_d == SHIFT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      run_q   <= '0;
      out_q   <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      run_q   <= run_d;
      out_q   <= out_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.S_TO_P_OUT = out_q;
  assign bus.ONES       = ones_q;
  assign bus.VALID      = valid_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_s_to_p.sv
// Scoreboard bench for s_to_p: a LEAD=2/WIDTH=16 instance and a LEAD=0/WIDTH=4 instance.
module tb_s_to_p;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [15:0] w;
    int          ones;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  s_to_p_if #(.WIDTH(16)) bus1();
  s_to_p_if #(.WIDTH(4))  bus2();

  s_to_p #(.WIDTH(16), .LEAD(2)) u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));
  s_to_p #(.WIDTH(4),  .LEAD(0)) u_dut2 (.CLK(clk), .RST_N(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation at every VALID pulse.
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (bus1.VALID === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected VALID", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 word", 32'(bus1.S_TO_P_OUT), 32'(e.w));
        chk("dut1 ones", 32'(bus1.ONES), 32'(e.ones));
        chk("dut1 valid cycle", 32'(cyc), 32'(e.cyc));
        chk("dut1 busy at valid", 32'(bus1.BUSY), 32'd0);
      end
    end
  end

  always begin
    exp_t e;
    @(posedge clk); #1;
    if (bus2.VALID === 1'b1) begin
      if (q2.size() == 0) chk("dut2 unexpected VALID", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("dut2 word", 32'(bus2.S_TO_P_OUT), 32'(e.w));
        chk("dut2 ones", 32'(bus2.ONES), 32'(e.ones));
        chk("dut2 valid cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drives one EN-low window on dut1: two lead-in slots (driven as 1s), nbits data bits,
  // hold cycles with EN still low, then one EN=1 cycle. Starts and ends at a negedge.
  task automatic frame1(input logic [15:0] w, input int ones, input int nbits, input int hold,
                        input logic [15:0] prev, input int prev_ones);
    exp_t e;
    int   idx;
    if (nbits == 16) begin
      e.w = w; e.ones = ones; e.cyc = cyc + 18;
      q1.push_back(e);
    end
    for (int i = 0; i < 2 + nbits; i++) begin
      idx = (i < 2) ? 0 : i - 2;
      bus1.EN = 1'b0;
      bus1.S_TO_P_IN = (i < 2) ? 1'b1 : w[idx];
      @(posedge clk); #1;
      if (i < 17) begin
        chk("busy in frame", 32'(bus1.BUSY), 32'd1);
        chk("out held in frame", 32'(bus1.S_TO_P_OUT), 32'(prev));
      end
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      bus1.EN = 1'b0;
      bus1.S_TO_P_IN = ~bus1.S_TO_P_IN;
      @(posedge clk); #1;
      chk("out held in DONE", 32'(bus1.S_TO_P_OUT), 32'(w));
      chk("busy in DONE", 32'(bus1.BUSY), 32'd0);
      @(negedge clk);
    end
    bus1.EN = 1'b1;
    @(posedge clk); #1;
    chk("out after EN high", 32'(bus1.S_TO_P_OUT), (nbits == 16) ? 32'(w) : 32'(prev));
    chk("ones after EN high", 32'(bus1.ONES), (nbits == 16) ? 32'(ones) : 32'(prev_ones));
    chk("busy after EN high", 32'(bus1.BUSY), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bits2;
    rst_n = 1'b0;
    bus1.EN = 1'b1; bus1.S_TO_P_IN = 1'b0;
    bus2.EN = 1'b1; bus2.S_TO_P_IN = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset out", 32'(bus1.S_TO_P_OUT), 32'd0);
    chk("reset ones", 32'(bus1.ONES), 32'd0);
    chk("reset valid", 32'(bus1.VALID), 32'd0);
    chk("reset busy", 32'(bus1.BUSY), 32'd0);
    chk("reset dut2 out", 32'(bus2.S_TO_P_OUT), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    frame1(16'hA5C3, 8, 16, 40, 16'h0000, 0);
    frame1(16'hFFFF, 16, 16, 2, 16'hA5C3, 8);
    frame1(16'h0000, 0, 16, 2, 16'hFFFF, 16);
    frame1(16'h1234, 0, 10, 0, 16'h0000, 0);
    frame1(16'h8001, 2, 16, 2, 16'h0000, 0);
    frame1(16'h7777, 0, 15, 0, 16'h8001, 2);

    // Reset in the middle of SHIFT: two lead slots then five data bits.
    for (int i = 0; i < 7; i++) begin
      bus1.EN = 1'b0; bus1.S_TO_P_IN = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    bus1.EN = 1'b1;
    #1;
    chk("async reset out", 32'(bus1.S_TO_P_OUT), 32'd0);
    chk("async reset ones", 32'(bus1.ONES), 32'd0);
    chk("async reset valid", 32'(bus1.VALID), 32'd0);
    chk("async reset busy", 32'(bus1.BUSY), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("busy after reset", 32'(bus1.BUSY), 32'd0);

    // LEAD=0 instance: bits 1,0,1,1 from the first EN-low edge.
    bits2 = 4'b1101;
    begin
      exp_t e;
      e.w = 16'h000D; e.ones = 3; e.cyc = cyc + 4;
      q2.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      bus2.EN = 1'b0; bus2.S_TO_P_IN = bits2[i];
      @(posedge clk); #1;
      if (i < 3) chk("dut2 busy in frame", 32'(bus2.BUSY), 32'd1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    bus2.EN = 1'b1;
    repeat (5) @(negedge clk);
    chk("dut2 held word", 32'(bus2.S_TO_P_OUT), 32'hD);

    chk("dut1 pending expectations", 32'(q1.size()), 32'd0);
    chk("dut2 pending expectations", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
